// File: rtl/etapa_salida.sv
// etapa_salida: sign/zero correction of the divider result and a small result FIFO.
// A registered correction stage feeds a Prof-entry FIFO; the head entry drives the outputs.
`default_nettype none

module etapa_salida #(
    parameter int AnchoDv = 15,
    parameter int AnchoDd = 31,
    parameter int AnchoQ  = 15,
    parameter int Prof    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    goIn,
    input  logic [AnchoDd:0]        dividendIn,
    input  logic [AnchoQ:0]         quotientIn,
    input  logic                    negDivisorIn,
    input  logic                    negDividendIn,
    input  logic                    DivisorNoCeroIn,
    input  logic                    readyIn,
    output logic                    validOut,
    output logic [AnchoQ:0]         quotientOut,
    output logic [AnchoQ:0]         remainderOut,
    output logic                    divZeroOut,
    output logic [$clog2(Prof):0]   countOut,
    output logic                    overflowErr
);

    localparam int QW = AnchoQ + 1;
    localparam int PW = $clog2(Prof);
    localparam int EW = 2 * QW + 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(Prof);
    localparam int unused_divisor_msb = AnchoDv;

    logic [AnchoQ:0] rem_mag;
    logic [AnchoQ:0] q_fix;
    logic [AnchoQ:0] r_fix;
    logic            dz_fix;

    // Only the top slice of the dividend register holds the remainder.
    assign rem_mag = dividendIn[AnchoDd -: QW];

    logic unused_bits;
    assign unused_bits = ^{1'b0, dividendIn[AnchoDd-QW:0]};

    always_comb begin
        q_fix  = quotientIn;
        r_fix  = rem_mag;
        dz_fix = 1'b0;
        if (!DivisorNoCeroIn) begin
            q_fix  = '1;
            r_fix  = '0;
            dz_fix = 1'b1;
        end else begin
            if (negDivisorIn ^ negDividendIn) q_fix = -quotientIn;
            if (negDividendIn)                r_fix = -rem_mag;
        end
    end

    logic            s1_valid;
    logic [AnchoQ:0] s1_q;
    logic [AnchoQ:0] s1_r;
    logic            s1_dz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_r     <= '0;
            s1_dz    <= 1'b0;
        end else begin
            s1_valid <= goIn;
            if (goIn) begin
                s1_q  <= q_fix;
                s1_r  <= r_fix;
                s1_dz <= dz_fix;
            end
        end
    end

    logic [EW-1:0] mem [Prof];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [EW-1:0] head;

    assign push  = s1_valid;
    assign pop   = validOut & readyIn;
    assign full  = (countOut == FULL_CNT);
    // A full FIFO still accepts a push on the edge it also pops.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s1_dz, s1_q, s1_r};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            countOut    <= '0;
            overflowErr <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   countOut <= countOut + 1'b1;
                2'b01:   countOut <= countOut - 1'b1;
                default: countOut <= countOut;
            endcase
            if (push & full & ~pop) overflowErr <= 1'b1;
        end
    end

    assign validOut     = (countOut != '0);
    assign head         = mem[rd_ptr];
    assign divZeroOut   = validOut ? head[EW-1] : 1'b0;
    assign quotientOut  = validOut ? head[2*QW-1:QW] : '0;
    assign remainderOut = validOut ? head[QW-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_etapa_salida.sv
// Bench for etapa_salida: queue-based reference model checked every cycle, plus literal cases.
`default_nettype none

module tb_etapa_salida;

    localparam int PROF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        goIn = 1'b0;
    logic [31:0] dividendIn = '0;
    logic [15:0] quotientIn = '0;
    logic        negDivisorIn = 1'b0;
    logic        negDividendIn = 1'b0;
    logic        DivisorNoCeroIn = 1'b1;
    logic        readyIn = 1'b0;
    logic        validOut;
    logic [15:0] quotientOut;
    logic [15:0] remainderOut;
    logic        divZeroOut;
    logic [2:0]  countOut;
    logic        overflowErr;

    int checks = 0;
    int failures = 0;

    etapa_salida #(.AnchoDv(15), .AnchoDd(31), .AnchoQ(15), .Prof(PROF)) dut (
        .clk(clk), .reset(reset), .goIn(goIn), .dividendIn(dividendIn),
        .quotientIn(quotientIn), .negDivisorIn(negDivisorIn),
        .negDividendIn(negDividendIn), .DivisorNoCeroIn(DivisorNoCeroIn),
        .readyIn(readyIn), .validOut(validOut), .quotientOut(quotientOut),
        .remainderOut(remainderOut), .divZeroOut(divZeroOut),
        .countOut(countOut), .overflowErr(overflowErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } res_t;

    // Truncating signed division result from magnitudes and sign flags.
    function automatic res_t expected(input logic [15:0] qm, input logic [15:0] rm,
                                      input logic nv, input logic nd, input logic nz);
        res_t e;
        int   qs;
        int   rs;
        if (!nz) begin
            e.q = 16'hFFFF; e.r = 16'd0; e.dz = 1'b1;
        end else begin
            qs = (nv != nd) ? -int'(qm) : int'(qm);
            rs = nd ? -int'(rm) : int'(rm);
            e.q = qs[15:0]; e.r = rs[15:0]; e.dz = 1'b0;
        end
        return e;
    endfunction

    res_t mq[$];
    res_t pend;
    bit   pend_v = 0;
    bit   m_ovf = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            pend_v = 0;
            m_ovf  = 0;
        end else begin
            if (mq.size() != 0 && readyIn) void'(mq.pop_front());
            if (pend_v) begin
                if (mq.size() < PROF) mq.push_back(pend);
                else m_ovf = 1;
            end
            pend_v = goIn;
            if (goIn) pend = expected(quotientIn, dividendIn[31:16], negDivisorIn,
                                      negDividendIn, DivisorNoCeroIn);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("valid", 32'(validOut), 32'(mq.size() != 0));
            chk("count", 32'(countOut), 32'(mq.size()));
            chk("overflow", 32'(overflowErr), 32'(m_ovf));
            if (mq.size() != 0) begin
                chk("quotient", 32'(quotientOut), 32'(mq[0].q));
                chk("remainder", 32'(remainderOut), 32'(mq[0].r));
                chk("divzero", 32'(divZeroOut), 32'(mq[0].dz));
            end
        end
    end

    task automatic drive(input bit go, input logic [15:0] q, input logic [15:0] rem,
                         input bit nv, input bit nd, input bit nz);
        goIn = go; quotientIn = q;
        dividendIn = {rem, 16'($urandom)};
        negDivisorIn = nv; negDividendIn = nd; DivisorNoCeroIn = nz;
    endtask

    // One result through an empty FIFO: visible after the second edge.
    task automatic one_shot(input string name, input logic [15:0] q, input logic [15:0] rem,
                            input bit nv, input bit nd, input bit nz,
                            input logic [15:0] eq, input logic [15:0] er, input bit edz);
        readyIn = 1'b0;
        drive(1, q, rem, nv, nd, nz);
        @(negedge clk);
        goIn = 1'b0;
        chk({name, "_lat1"}, 32'(validOut), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(validOut), 32'd1);
        chk({name, "_q"}, 32'(quotientOut), 32'(eq));
        chk({name, "_r"}, 32'(remainderOut), 32'(er));
        chk({name, "_dz"}, 32'(divZeroOut), 32'(edz));
        readyIn = 1'b1;
        @(negedge clk);
        readyIn = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_valid", 32'(validOut), 32'd0);
        chk("reset_count", 32'(countOut), 32'd0);
        chk("reset_q", 32'(quotientOut), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        one_shot("pos_pos", 16'd14, 16'd2, 0, 0, 1, 16'd14, 16'd2, 0);
        one_shot("neg_dividend", 16'd14, 16'd2, 0, 1, 1, 16'hFFF2, 16'hFFFE, 0);
        one_shot("neg_divisor", 16'd14, 16'd2, 1, 0, 1, 16'hFFF2, 16'd2, 0);
        one_shot("div_zero", 16'd14, 16'd2, 0, 1, 0, 16'hFFFF, 16'd0, 1);
        one_shot("neg_zero_rem", 16'd5, 16'd0, 1, 1, 1, 16'd5, 16'd0, 0);

        // Three stored entries plus one in flight, then reset between edges.
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(i + 10), 16'd1, 0, 0, 1);
            @(negedge clk);
        end
        goIn = 1'b0;
        chk("pre_reset_count", 32'(countOut), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 32'(validOut), 32'd0);
        chk("async_count", 32'(countOut), 32'd0);
        chk("async_q", 32'(quotientOut), 32'd0);
        chk("async_r", 32'(remainderOut), 32'd0);
        chk("async_dz", 32'(divZeroOut), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_empty", 32'(validOut), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'(i + 1), 16'd0, 0, 0, 1);
            @(negedge clk);
        end
        chk("full_count", 32'(countOut), 32'd4);
        readyIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(i + 6), 16'd0, 0, 0, 1);
            @(negedge clk);
        end
        chk("pushpop_count", 32'(countOut), 32'd4);
        chk("pushpop_ovf", 32'(overflowErr), 32'd0);
        chk("pushpop_head", 32'(quotientOut), 32'd4);
        goIn = 1'b0;
        readyIn = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Overflow: five pulses into four slots, then drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'(i + 1), 16'd0, 0, 0, 1);
            @(negedge clk);
        end
        goIn = 1'b0;
        @(negedge clk);
        chk("ovf_count", 32'(countOut), 32'd4);
        chk("ovf_flag", 32'(overflowErr), 32'd1);
        readyIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(quotientOut), 32'(i + 1));
            @(negedge clk);
        end
        chk("drain_empty", 32'(validOut), 32'd0);
        chk("ovf_sticky", 32'(overflowErr), 32'd1);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) != 0));
            readyIn = ($urandom_range(0, 99) < 55);
            if (i == 1500) begin
                #3 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(negedge clk);
        end
        goIn = 1'b0;
        readyIn = 1'b1;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/etapa_salida.md
ETAPA_SALIDA -- requirements
Module: etapa_salida

Parameters
REQ-001 The block SHALL have parameter AnchoDv, default 15, meaning MSB index of divisor path (16 bits).
REQ-002 The block SHALL have parameter AnchoDd, default 31, meaning MSB index of dividend path (32 bits).
REQ-003 The block SHALL have parameter AnchoQ, default 15, meaning MSB index of quotient and remainder results (16 bits).
REQ-004 The block SHALL have parameter Prof, default 4, meaning result FIFO depth in entries (power of two, 2..16).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port goIn, input, 1 bit: last divider pipeline stage holds a valid result this cycle.
REQ-008 The block SHALL have port dividendIn, input, AnchoDd+1 bits: final dividend register; bits [AnchoDd:AnchoDd-AnchoQ] carry the unsigned remainder.
REQ-009 The block SHALL have port quotientIn, input, AnchoQ+1 bits: unsigned quotient.
REQ-010 The block SHALL have ports negDivisorIn, negDividendIn and DivisorNoCeroIn, input, 1 bit each: sign/zero flags carried down the pipeline.
REQ-011 The block SHALL have port readyIn, input, 1 bit: consumer accepts the head result this cycle.
REQ-012 The block SHALL have ports validOut, output, 1 bit, and quotientOut/remainderOut, output, AnchoQ+1 bits each: signed head result.
REQ-013 The block SHALL have port divZeroOut, output, 1 bit: head result came from a zero divisor.
REQ-014 The block SHALL have ports countOut, output, clog2(Prof)+1 bits (FIFO occupancy), and overflowErr, output, 1 bit (sticky drop flag).

Function
REQ-015 Stage 1 (correction register) SHALL capture on every rising edge with goIn=1; captured valid bit = goIn.
REQ-016 Quotient sign SHALL be negDivisorIn XOR negDividendIn; when set, quotient SHALL be two's-complement negated modulo 2^(AnchoQ+1).
REQ-017 Remainder sign SHALL follow negDividendIn (truncating division); when set, remainder SHALL be negated; remainder zero stays zero.
REQ-018 DivisorNoCeroIn=0 SHALL force quotient to all ones, remainder to 0, divZero flag 1, ignoring sign flags.
REQ-019 Stage 1 valid entry SHALL be pushed into the FIFO on the following edge; goIn at edge N -> validOut=1 after edge N+1 when FIFO was empty (2-cycle latency).
REQ-020 Outputs SHALL present the FIFO head directly from registers; validOut = (countOut != 0).
REQ-021 Pop SHALL occur on an edge where validOut=1 and readyIn=1; readyIn with validOut=0 SHALL have no effect.
REQ-022 Simultaneous push and pop SHALL leave countOut unchanged, including when full and when count=1 (new entry becomes head).
REQ-023 Push when full without pop SHALL drop the new entry, keep FIFO contents, and set overflowErr=1 until reset.
REQ-024 Read and write pointers SHALL wrap modulo Prof; entries SHALL exit in push order.
REQ-025 Upstream has no backpressure; the block SHALL never stall goIn.

Reset
REQ-026 reset=0 SHALL asynchronously clear stage 1 valid, pointers, countOut, overflowErr, validOut, quotientOut, remainderOut and divZeroOut to 0.
REQ-027 Reset mid-operation SHALL discard all stored and in-flight results; first goIn after release SHALL follow REQ-019.

Verification
REQ-028 100/7: quotientIn=14, remainder=2, flags 0,0,1, readyIn=1 -> validOut 2 cycles later, quotientOut=14, remainderOut=2, divZeroOut=0.
REQ-029 -100/7: negDividendIn=1, same magnitudes -> quotientOut=16'hFFF2 (-14), remainderOut=16'hFFFE (-2); 100/-7 -> quotient -14, remainder +2.
REQ-030 Divisor zero: DivisorNoCeroIn=0, negDividendIn=1 -> quotientOut=16'hFFFF, remainderOut=0, divZeroOut=1.
REQ-031 readyIn=0, 5 consecutive goIn pulses (Prof=4) -> countOut=4, overflowErr=1, then readyIn=1 drains results 1..4 in order, 5th absent.
REQ-032 Full FIFO, goIn and readyIn both 1 on same edge -> countOut stays 4, overflowErr stays 0, order preserved.
REQ-033 reset=0 asserted between clk edges with 3 entries stored -> all outputs 0 immediately, no result emitted after release.
